// File: rtl/fixed_point_gather_pkg.sv
// Shared types and helpers for the fixed-point gather datapath.
package fixed_point_pkg;

    typedef enum logic [0:0] {
        RD_IDLE = 1'b0,
        RD_HOLD = 1'b1
    } rd_state_t;

    // Lane pointer width for a given vector length (never narrower than 1 bit).
    function automatic int lane_ptr_w(input int num_lanes);
        return (num_lanes > 1) ? $clog2(num_lanes) : 1;
    endfunction

endpackage

// File: rtl/fixed_point_gather_if.sv
// Serial-in / packed-out handshake bundle for fixed_point_gather.
interface fixed_point_gather_if #(
    parameter int WIDTH       = 8,
    parameter int NUM_OUTPUTS = 16
) ();
    logic signed [WIDTH-1:0]             VALUE_IN;
    logic                                VALID_IN;
    logic                                READY_OUT;
    logic signed [NUM_OUTPUTS*WIDTH-1:0] VALUES_OUT;
    logic                                VALID_OUT;
    logic                                RELEASE_IN;

    modport master (
        output VALUE_IN, VALID_IN, RELEASE_IN,
        input  READY_OUT, VALUES_OUT, VALID_OUT
    );

    modport slave (
        input  VALUE_IN, VALID_IN, RELEASE_IN,
        output READY_OUT, VALUES_OUT, VALID_OUT
    );
endinterface

// File: rtl/fixed_point_gather_buffer.sv
// One gather buffer: lane storage, write pointer and full flag.
module fixed_point_gather_buffer
    import fixed_point_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int NUM_OUTPUTS = 16
) (
    input  logic                           CLK,
    input  logic                           RSTN,
    input  logic                           wr_en,
    input  logic signed [WIDTH-1:0]        wr_data,
    input  logic                           clr,
    output logic [NUM_OUTPUTS*WIDTH-1:0]   vec,
    output logic                           full,
    output logic                           last
);
    localparam int PTR_W = lane_ptr_w(NUM_OUTPUTS);
    localparam logic [PTR_W-1:0] LAST_LANE = PTR_W'(NUM_OUTPUTS - 1);

    logic [PTR_W-1:0]                       wr_ptr;
    logic [NUM_OUTPUTS-1:0][WIDTH-1:0]      lanes;

    assign last = (wr_ptr == LAST_LANE);
    assign vec  = lanes;

    // clr and a write never target the same buffer in one cycle: a full buffer refuses beats.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            wr_ptr <= '0;
            full   <= 1'b0;
            lanes  <= '0;
        end else begin
            if (clr) begin
                full <= 1'b0;
            end
            if (wr_en && !full) begin
                lanes[wr_ptr] <= wr_data;
                if (last) begin
                    wr_ptr <= '0;
                    full   <= 1'b1;
                end else begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/fixed_point_gather.sv
// Serial-to-parallel gather of fixed-point operands with a held output vector.
// Build option: FIXED_POINT_GATHER_PINGPONG_EN selects two alternating buffers.
module fixed_point_gather
    import fixed_point_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int FRAC_BITS   = 3,
    parameter int NUM_OUTPUTS = 16
) (
    input  logic                 CLK,
    input  logic                 RSTN,
    fixed_point_gather_if.slave  bus
);
    // state   | meaning
    // RD_IDLE | waiting for the selected buffer to fill
    // RD_HOLD | vector presented, waiting for RELEASE_IN

`ifdef FIXED_POINT_GATHER_PINGPONG_EN
    localparam int   NUM_BUF  = 2;
    localparam logic PINGPONG = 1'b1;
`else
    localparam int   NUM_BUF  = 1;
    localparam logic PINGPONG = 1'b0;
`endif

    if (FRAC_BITS <= 0 || FRAC_BITS >= WIDTH || NUM_OUTPUTS < 2) begin : g_bad_cfg
        $error("fixed_point_gather: invalid WIDTH/FRAC_BITS/NUM_OUTPUTS");
    end

    logic                                        wr_sel;
    logic                                        rd_sel;
    logic                                        ready;
    logic                                        accept;
    logic                                        wr_wrap;
    logic                                        load_out;
    logic                                        rel_acc;
    logic [NUM_BUF-1:0]                          buf_wr;
    logic [NUM_BUF-1:0]                          buf_clr;
    logic [NUM_BUF-1:0]                          buf_full;
    logic [NUM_BUF-1:0]                          buf_last;
    logic [NUM_BUF-1:0][NUM_OUTPUTS*WIDTH-1:0]   buf_vec;
    logic [NUM_OUTPUTS*WIDTH-1:0]                vals_q;
    logic                                        valid_q;
    rd_state_t                                   state_q;
    rd_state_t                                   state_d;

    assign ready   = !buf_full[wr_sel];
    assign accept  = bus.VALID_IN && ready;
    assign wr_wrap = accept && buf_last[wr_sel];

    for (genvar b = 0; b < NUM_BUF; b++) begin : g_buf
        assign buf_wr[b]  = accept  && (wr_sel == 1'(b));
        assign buf_clr[b] = rel_acc && (rd_sel == 1'(b));

        fixed_point_gather_buffer #(
            .WIDTH       (WIDTH),
            .NUM_OUTPUTS (NUM_OUTPUTS)
        ) u_buf (
            .CLK     (CLK),
            .RSTN    (RSTN),
            .wr_en   (buf_wr[b]),
            .wr_data (bus.VALUE_IN),
            .clr     (buf_clr[b]),
            .vec     (buf_vec[b]),
            .full    (buf_full[b]),
            .last    (buf_last[b])
        );
    end

    // Selects stay at 0 in the single-buffer build.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            wr_sel <= 1'b0;
            rd_sel <= 1'b0;
        end else begin
            wr_sel <= (wr_sel ^ wr_wrap) & PINGPONG;
            rd_sel <= (rd_sel ^ rel_acc) & PINGPONG;
        end
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q <= RD_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RD_IDLE: if (buf_full[rd_sel]) state_d = RD_HOLD;
            RD_HOLD: if (bus.RELEASE_IN)   state_d = RD_IDLE;
            default:                       state_d = RD_IDLE;
        endcase
    end

    always_comb begin
        load_out = 1'b0;
        rel_acc  = 1'b0;
        case (state_q)
            RD_IDLE: load_out = buf_full[rd_sel];
            RD_HOLD: rel_acc  = bus.RELEASE_IN;
            default: ;
        endcase
    end

    // Vector register only reloads on issue, so it stays frozen through HOLD and after release.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            valid_q <= 1'b0;
            vals_q  <= '0;
        end else begin
            valid_q <= load_out;
            if (load_out) begin
                vals_q <= buf_vec[rd_sel];
            end
        end
    end

    assign bus.READY_OUT  = ready;
    assign bus.VALID_OUT  = valid_q;
    assign bus.VALUES_OUT = vals_q;

endmodule

// File: tb/tb_fixed_point_gather.sv
// Directed self-checking bench for fixed_point_gather (WIDTH=8, NUM_OUTPUTS=4).
module tb_fixed_point_gather;

    logic clk;
    logic rstn;
    int   vectors;
    int   miscompares;
    int   pulses;

    fixed_point_gather_if #(.WIDTH(8), .NUM_OUTPUTS(4)) bus ();

    fixed_point_gather #(
        .WIDTH       (8),
        .FRAC_BITS   (3),
        .NUM_OUTPUTS (4)
    ) dut (
        .CLK  (clk),
        .RSTN (rstn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rstn && bus.VALID_OUT) pulses++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offers one beat and holds it until it transfers (bounded).
    task automatic drive_beat(input logic [7:0] v);
        logic ready_now;
        bit   done;
        done = 1'b0;
        bus.VALUE_IN = v;
        bus.VALID_IN = 1'b1;
        for (int i = 0; i < 50 && !done; i++) begin
            ready_now = bus.READY_OUT;
            step();
            if (ready_now) done = 1'b1;
        end
        bus.VALID_IN = 1'b0;
        if (!done) begin
            miscompares++;
            $display("FAIL beat_timeout: beat %h never accepted, required acceptance within 50 cycles", v);
        end
        vectors++;
    endtask

    task automatic release_pulse();
        bus.RELEASE_IN = 1'b1;
        step();
        bus.RELEASE_IN = 1'b0;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        step();
        step();
        if (bus.VALID_OUT !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b required 0", bus.VALID_OUT); end
        vectors++;
        if (bus.VALUES_OUT !== 32'h0) begin miscompares++; $display("FAIL reset_values: got %h required 00000000", bus.VALUES_OUT); end
        vectors++;
        rstn = 1'b1;
        step();
        if (bus.READY_OUT !== 1'b1) begin miscompares++; $display("FAIL reset_ready: got %b required 1", bus.READY_OUT); end
        vectors++;
    endtask

    task automatic test_basic_fill();
        int p0;
        p0 = pulses;
        drive_beat(8'h08);
        drive_beat(8'h10);
        drive_beat(8'hF8);
        drive_beat(8'h04);
        if (bus.VALID_OUT !== 1'b0) begin miscompares++; $display("FAIL basic_early_valid: got %b required 0", bus.VALID_OUT); end
        vectors++;
        step();
        if (bus.VALID_OUT !== 1'b1) begin miscompares++; $display("FAIL basic_valid: got %b required 1", bus.VALID_OUT); end
        vectors++;
        if (bus.VALUES_OUT !== 32'h04F81008) begin miscompares++; $display("FAIL basic_values: got %h required 04F81008", bus.VALUES_OUT); end
        vectors++;
        step();
        if (bus.VALID_OUT !== 1'b0) begin miscompares++; $display("FAIL basic_pulse_width: got %b required 0", bus.VALID_OUT); end
        vectors++;
        repeat (3) step();
        if (bus.VALUES_OUT !== 32'h04F81008) begin miscompares++; $display("FAIL basic_hold: got %h required 04F81008", bus.VALUES_OUT); end
        vectors++;
`ifdef FIXED_POINT_GATHER_PINGPONG_EN
        if (bus.READY_OUT !== 1'b1) begin miscompares++; $display("FAIL basic_ready_hold: got %b required 1", bus.READY_OUT); end
`else
        if (bus.READY_OUT !== 1'b0) begin miscompares++; $display("FAIL basic_ready_hold: got %b required 0", bus.READY_OUT); end
`endif
        vectors++;
        release_pulse();
        if (bus.READY_OUT !== 1'b1) begin miscompares++; $display("FAIL basic_ready_release: got %b required 1", bus.READY_OUT); end
        vectors++;
        repeat (2) step();
        if (pulses - p0 !== 1) begin miscompares++; $display("FAIL basic_pulse_count: got %0d required 1", pulses - p0); end
        vectors++;
    endtask

    task automatic test_back_to_back();
        int p0;
        p0 = pulses;
`ifdef FIXED_POINT_GATHER_PINGPONG_EN
        for (int i = 0; i < 8; i++) begin
            if (bus.READY_OUT !== 1'b1) begin miscompares++; $display("FAIL b2b_ready_beat%0d: got %b required 1", i + 1, bus.READY_OUT); end
            vectors++;
            drive_beat(8'h21 + 8'(i));
        end
        if (bus.READY_OUT !== 1'b0) begin miscompares++; $display("FAIL b2b_ready_full: got %b required 0", bus.READY_OUT); end
        vectors++;
        if (bus.VALUES_OUT !== 32'h24232221) begin miscompares++; $display("FAIL b2b_first_values: got %h required 24232221", bus.VALUES_OUT); end
        vectors++;
        release_pulse();
        if (bus.VALID_OUT !== 1'b0) begin miscompares++; $display("FAIL b2b_valid_at_release: got %b required 0", bus.VALID_OUT); end
        vectors++;
        step();
        if (bus.VALID_OUT !== 1'b1) begin miscompares++; $display("FAIL b2b_second_valid: got %b required 1", bus.VALID_OUT); end
        vectors++;
        if (bus.VALUES_OUT !== 32'h28272625) begin miscompares++; $display("FAIL b2b_second_values: got %h required 28272625", bus.VALUES_OUT); end
        vectors++;
        if (pulses - p0 !== 2) begin miscompares++; $display("FAIL b2b_pulse_count: got %0d required 2", pulses - p0); end
        vectors++;
`else
        for (int i = 0; i < 4; i++) drive_beat(8'h21 + 8'(i));
        if (bus.READY_OUT !== 1'b0) begin miscompares++; $display("FAIL b2b_ready_full: got %b required 0", bus.READY_OUT); end
        vectors++;
        step();
        if (bus.VALID_OUT !== 1'b1) begin miscompares++; $display("FAIL b2b_first_valid: got %b required 1", bus.VALID_OUT); end
        vectors++;
        if (bus.VALUES_OUT !== 32'h24232221) begin miscompares++; $display("FAIL b2b_first_values: got %h required 24232221", bus.VALUES_OUT); end
        vectors++;
        step();
        if (bus.READY_OUT !== 1'b0) begin miscompares++; $display("FAIL b2b_ready_hold: got %b required 0", bus.READY_OUT); end
        vectors++;
        release_pulse();
        if (bus.READY_OUT !== 1'b1) begin miscompares++; $display("FAIL b2b_ready_release: got %b required 1", bus.READY_OUT); end
        vectors++;
        for (int i = 4; i < 8; i++) drive_beat(8'h21 + 8'(i));
        step();
        if (bus.VALID_OUT !== 1'b1) begin miscompares++; $display("FAIL b2b_second_valid: got %b required 1", bus.VALID_OUT); end
        vectors++;
        if (bus.VALUES_OUT !== 32'h28272625) begin miscompares++; $display("FAIL b2b_second_values: got %h required 28272625", bus.VALUES_OUT); end
        vectors++;
`endif
        release_pulse();
        step();
    endtask

    task automatic test_gapped();
        logic [6:0] pattern;
        logic [7:0] next_val;
        pattern  = 7'b1001101;
        next_val = 8'h01;
        for (int i = 0; i < 7; i++) begin
            bus.VALID_IN = pattern[6 - i];
            bus.VALUE_IN = pattern[6 - i] ? next_val : 8'hEE;
            step();
            if (pattern[6 - i]) next_val = next_val + 8'h01;
        end
        bus.VALID_IN = 1'b0;
        step();
        if (bus.VALID_OUT !== 1'b1) begin miscompares++; $display("FAIL gapped_valid: got %b required 1", bus.VALID_OUT); end
        vectors++;
        if (bus.VALUES_OUT !== 32'h04030201) begin miscompares++; $display("FAIL gapped_values: got %h required 04030201", bus.VALUES_OUT); end
        vectors++;
        release_pulse();
        step();
    endtask

    task automatic test_coincident();
`ifdef FIXED_POINT_GATHER_PINGPONG_EN
        for (int i = 0; i < 4; i++) drive_beat(8'h31 + 8'(i));
        for (int i = 0; i < 3; i++) drive_beat(8'h41 + 8'(i));
        bus.VALUE_IN   = 8'h44;
        bus.VALID_IN   = 1'b1;
        bus.RELEASE_IN = 1'b1;
        step();
        bus.VALID_IN   = 1'b0;
        bus.RELEASE_IN = 1'b0;
        if (bus.READY_OUT !== 1'b1) begin miscompares++; $display("FAIL coinc_ready: got %b required 1", bus.READY_OUT); end
        vectors++;
        if (bus.VALUES_OUT !== 32'h34333231) begin miscompares++; $display("FAIL coinc_old_values: got %h required 34333231", bus.VALUES_OUT); end
        vectors++;
        step();
        if (bus.VALID_OUT !== 1'b1) begin miscompares++; $display("FAIL coinc_valid: got %b required 1", bus.VALID_OUT); end
        vectors++;
        if (bus.VALUES_OUT !== 32'h44434241) begin miscompares++; $display("FAIL coinc_values: got %h required 44434241", bus.VALUES_OUT); end
        vectors++;
        release_pulse();
        step();
`endif
    endtask

    task automatic test_spurious_release();
        int p0;
        p0 = pulses;
        release_pulse();
        step();
        if (bus.VALUES_OUT !== 32'h04030201) begin miscompares++; $display("FAIL spur_idle_values: got %h required 04030201", bus.VALUES_OUT); end
        vectors++;
        if (pulses - p0 !== 0) begin miscompares++; $display("FAIL spur_idle_pulse: got %0d required 0", pulses - p0); end
        vectors++;
        for (int i = 0; i < 4; i++) drive_beat(8'h51 + 8'(i));
        bus.RELEASE_IN = 1'b1;
        step();
        bus.RELEASE_IN = 1'b0;
        if (bus.VALID_OUT !== 1'b1) begin miscompares++; $display("FAIL spur_valid: got %b required 1", bus.VALID_OUT); end
        vectors++;
        if (bus.VALUES_OUT !== 32'h54535251) begin miscompares++; $display("FAIL spur_values: got %h required 54535251", bus.VALUES_OUT); end
        vectors++;
        repeat (2) step();
`ifdef FIXED_POINT_GATHER_PINGPONG_EN
        for (int i = 0; i < 4; i++) drive_beat(8'h61 + 8'(i));
        repeat (2) step();
        if (bus.VALUES_OUT !== 32'h54535251) begin miscompares++; $display("FAIL spur_still_held: got %h required 54535251", bus.VALUES_OUT); end
        vectors++;
        if (pulses - p0 !== 1) begin miscompares++; $display("FAIL spur_pulse_count: got %0d required 1", pulses - p0); end
        vectors++;
        release_pulse();
        step();
        if (bus.VALUES_OUT !== 32'h64636261) begin miscompares++; $display("FAIL spur_next_values: got %h required 64636261", bus.VALUES_OUT); end
        vectors++;
        release_pulse();
        step();
`else
        if (bus.READY_OUT !== 1'b0) begin miscompares++; $display("FAIL spur_still_held: got %b required 0", bus.READY_OUT); end
        vectors++;
        if (pulses - p0 !== 1) begin miscompares++; $display("FAIL spur_pulse_count: got %0d required 1", pulses - p0); end
        vectors++;
        release_pulse();
        if (bus.READY_OUT !== 1'b1) begin miscompares++; $display("FAIL spur_ready_release: got %b required 1", bus.READY_OUT); end
        vectors++;
        step();
`endif
    endtask

    task automatic test_reset_midfill();
        drive_beat(8'h99);
        drive_beat(8'h98);
        rstn = 1'b0;
        #1;
        if (bus.VALUES_OUT !== 32'h0) begin miscompares++; $display("FAIL midrst_values: got %h required 00000000", bus.VALUES_OUT); end
        vectors++;
        if (bus.VALID_OUT !== 1'b0) begin miscompares++; $display("FAIL midrst_valid: got %b required 0", bus.VALID_OUT); end
        vectors++;
        step();
        rstn = 1'b1;
        if (bus.READY_OUT !== 1'b1) begin miscompares++; $display("FAIL midrst_ready: got %b required 1", bus.READY_OUT); end
        vectors++;
        drive_beat(8'h11);
        drive_beat(8'h22);
        drive_beat(8'h33);
        drive_beat(8'h44);
        step();
        if (bus.VALID_OUT !== 1'b1) begin miscompares++; $display("FAIL midrst_refill_valid: got %b required 1", bus.VALID_OUT); end
        vectors++;
        if (bus.VALUES_OUT !== 32'h44332211) begin miscompares++; $display("FAIL midrst_refill_values: got %h required 44332211", bus.VALUES_OUT); end
        vectors++;
        release_pulse();
        step();
    endtask

    initial begin
        vectors        = 0;
        miscompares    = 0;
        pulses         = 0;
        rstn           = 1'b0;
        bus.VALUE_IN   = '0;
        bus.VALID_IN   = 1'b0;
        bus.RELEASE_IN = 1'b0;
        test_reset();
        test_basic_fill();
        test_back_to_back();
        test_gapped();
        test_spurious_release();
        test_coincident();
        test_reset_midfill();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
